// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
// Optional bus watchdog is enabled with `define WB_ARB_WDOG_EN (see wb_rr_arbiter).
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 32;

  // Index width with a floor of one bit so single-master builds still have a pointer.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr wins.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NM = 4,
  parameter int PW = clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] win,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NM; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NM) j = j - NM;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin shared-bus Wishbone arbiter: NM masters, one slave, ownership held while CYC.
// `define WB_ARB_WDOG_EN adds M_ERR_O and a stalled-slave watchdog of WDOG_LIMIT cycles.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM         = 4,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int WDOG_LIMIT = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [NM-1:0]    M_CYC_I,
  input  logic [NM-1:0]    M_STB_I,
  input  logic [NM-1:0]    M_WE_I,
  input  logic [NM*AW-1:0] M_ADR_I,
  input  logic [NM*DW-1:0] M_DAT_I,
  output logic [NM-1:0]    M_ACK_O,
  output logic [DW-1:0]    M_DAT_O,
  output logic [NM-1:0]    GNT_O,
`ifdef WB_ARB_WDOG_EN
  output logic [NM-1:0]    M_ERR_O,
`endif
  output logic             S_CYC_O,
  output logic             S_STB_O,
  output logic             S_WE_O,
  output logic [AW-1:0]    S_ADR_O,
  output logic [DW-1:0]    S_DAT_O,
  input  logic [DW-1:0]    S_DAT_I,
  input  logic             S_ACK_I
);

  localparam int PW = clog2(NM);

  arb_state_e    state;
  logic [NM-1:0] gnt;
  logic [PW-1:0] own;
  logic [PW-1:0] ptr;

  logic [NM-1:0] pick_win;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic          busy;
  logic          arb_en;
  logic          stb_raw;
  logic          ack_v;
  logic          wdog_hit;

  wb_rr_pick #(.NM(NM), .PW(PW)) u_pick (
    .req   (M_CYC_I),
    .ptr   (ptr),
    .win   (pick_win),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy   = (state == BUSY);
  // Re-arbitrate at the edge where the owner lets go, so handover costs no dead cycle.
  assign arb_en = !busy || !M_CYC_I[own];

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled at the edge.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state <= IDLE;
      gnt   <= '0;
      own   <= '0;
      ptr   <= '0;
    end else if (arb_en) begin
      if (pick_valid) begin
        state <= BUSY;
        gnt   <= pick_win;
        own   <= pick_idx;
        ptr   <= (pick_idx == PW'(NM - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end

  // ACK is qualified by the owner's STB, not its CYC, so a release in the ACK cycle still completes.
  assign stb_raw = busy && M_STB_I[own];
  assign ack_v   = stb_raw && S_ACK_I;

  assign GNT_O   = gnt;
  assign M_DAT_O = S_DAT_I;
  assign M_ACK_O = ack_v ? gnt : '0;
  assign S_CYC_O = busy && M_CYC_I[own];
  assign S_STB_O = stb_raw && !wdog_hit;
  assign S_WE_O  = busy && M_WE_I[own];
  assign S_ADR_O = busy ? M_ADR_I[own*AW +: AW] : '0;
  assign S_DAT_O = busy ? M_DAT_I[own*DW +: DW] : '0;

`ifdef WB_ARB_WDOG_EN
  localparam int WW = clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] wcnt;

  // Reaching the limit requires no ACK this cycle, so ACK always wins a tie.
  assign wdog_hit = stb_raw && !S_ACK_I && (wcnt == WW'(WDOG_LIMIT - 1));
  assign M_ERR_O  = wdog_hit ? gnt : '0;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      wcnt <= '0;
    end else if (arb_en || S_ACK_I || wdog_hit) begin
      wcnt <= '0;
    end else if (stb_raw) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_wdog_limit;
  assign unused_wdog_limit = WDOG_LIMIT;
  assign wdog_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (NM=4, AW=3, DW=32).
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 3;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM-1:0]    m_ack, gnt;
  logic [DW-1:0]    m_dat_o;
  logic             s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat, s_dat_i;
`ifdef WB_ARB_WDOG_EN
  logic [NM-1:0]    m_err;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .WDOG_LIMIT(16)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .M_CYC_I (m_cyc),
    .M_STB_I (m_stb),
    .M_WE_I  (m_we),
    .M_ADR_I (m_adr),
    .M_DAT_I (m_dat),
    .M_ACK_O (m_ack),
    .M_DAT_O (m_dat_o),
    .GNT_O   (gnt),
`ifdef WB_ARB_WDOG_EN
    .M_ERR_O (m_err),
`endif
    .S_CYC_O (s_cyc),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADR_O (s_adr),
    .S_DAT_O (s_dat),
    .S_DAT_I (s_dat_i),
    .S_ACK_I (s_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after another unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_ack = 1'b0; s_dat_i = '0;
    tick(); tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_scyc", 32'(s_cyc), 0);
    check("rst_sstb", 32'(s_stb), 0);
    check("rst_swe", 32'(s_we), 0);
    check("rst_sadr", 32'(s_adr), 0);
    check("rst_sdat", s_dat, 0);
    check("rst_mack", 32'(m_ack), 0);
    rst = 1'b1;

    // Single master write: m1 writes 5 to address 3.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1*AW +: AW] = 3'd3; m_dat[1*DW +: DW] = 32'h0000_0005;
    #1;
    check("t1_lat_gnt", 32'(gnt), 0);
    check("t1_lat_scyc", 32'(s_cyc), 0);
    tick();
    check("t1_gnt", 32'(gnt), 32'h2);
    check("t1_scyc", 32'(s_cyc), 1);
    check("t1_sstb", 32'(s_stb), 1);
    check("t1_swe", 32'(s_we), 1);
    check("t1_sadr", 32'(s_adr), 3);
    check("t1_sdat", s_dat, 5);
    check("t1_noack", 32'(m_ack), 0);
    s_ack = 1'b1; m_cyc[1] = 1'b0;
    #1;
    check("t1_ack", 32'(m_ack), 32'h2);
    tick();
    s_ack = 1'b0; m_stb = '0; m_we = '0;
    #1;
    check("t1_idle", 32'(gnt), 0);

    // Reset returns the pointer to 0 before the fairness run.
    rst = 1'b0; tick(); rst = 1'b1;

    // All four request; each releases in its ACK cycle.
    m_cyc = 4'hF; m_stb = 4'hF;
    tick();
    for (int k = 0; k < NM; k++) begin
      check($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(1 << k));
      s_ack = 1'b1; m_cyc[k] = 1'b0;
      if (k == NM - 1) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      end
      #1;
      check($sformatf("rot_ack%0d", k), 32'(m_ack), 32'(1 << k));
      tick();
    end
    check("rot_wrap", 32'(gnt), 32'h1);
    m_cyc[0] = 1'b0;
    #1;
    check("rot_wrap_ack", 32'(m_ack), 32'h1);
    tick();
    s_ack = 1'b0; m_stb = '0;
    #1;
    check("rot_idle", 32'(gnt), 0);

    // m2 holds a locked cycle with STB low; m0 must wait.
    m_cyc[2] = 1'b1;
    tick();
    check("lock_gnt", 32'(gnt), 32'h4);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0*AW +: AW] = 3'd5;
    s_ack = 1'b1;
    #1;
    check("lock_stray_ack", 32'(m_ack), 0);
    check("lock_sstb", 32'(s_stb), 0);
    s_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lock_hold%0d", i), 32'(gnt), 32'h4);
    end
    m_cyc[2] = 1'b0;
    tick();
    check("lock_handover", 32'(gnt), 32'h1);
    check("lock_m0_sstb", 32'(s_stb), 1);
    check("lock_m0_sadr", 32'(s_adr), 5);
    m_cyc[0] = 1'b0;
    tick();
    m_stb = '0;
    #1;
    check("lock_idle", 32'(gnt), 0);

    // Stray slave ACK while idle.
    s_ack = 1'b1;
    #1;
    check("idle_stray_ack", 32'(m_ack), 0);
    check("idle_scyc", 32'(s_cyc), 0);
    s_ack = 1'b0;

    // Reset during m3's read, then m1/m3 contend.
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b0; m_adr[3*AW +: AW] = 3'd6;
    tick();
    check("rd_gnt", 32'(gnt), 32'h8);
    check("rd_swe", 32'(s_we), 0);
    check("rd_sadr", 32'(s_adr), 6);
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd_mdat", m_dat_o, 32'hDEAD_BEEF);
    rst = 1'b0;
    tick();
    check("rstmid_gnt", 32'(gnt), 0);
    check("rstmid_scyc", 32'(s_cyc), 0);
    check("rstmid_sstb", 32'(s_stb), 0);
    m_cyc = '0; m_stb = '0; rst = 1'b1;
    tick();
    m_cyc = 4'b1010; m_stb = 4'b1010;
    tick();
    check("post_rst_m1", 32'(gnt), 32'h2);
    check("post_rst_sadr", 32'(s_adr), 3);
    m_cyc = '0;
    tick();
    m_stb = '0;
    #1;
    check("post_rst_idle", 32'(gnt), 0);

`ifdef WB_ARB_WDOG_EN
    // Slave never acknowledges: ERR on the 16th STB cycle with STB suppressed.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    for (int i = 1; i < 16; i++) begin
      check($sformatf("wdog_noerr%0d", i), 32'(m_err), 0);
      check($sformatf("wdog_stb%0d", i), 32'(s_stb), 1);
      tick();
    end
    check("wdog_err", 32'(m_err), 32'h2);
    check("wdog_stb_forced", 32'(s_stb), 0);
    tick();
    check("wdog_err_clr", 32'(m_err), 0);
    check("wdog_keep_gnt", 32'(gnt), 32'h2);
    check("wdog_stb_back", 32'(s_stb), 1);
    m_cyc = '0; m_stb = '0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shared-bus Wishbone arbiter. It lets NM masters share one slave port, such as the 8-register, 32-bit slave used by the point-to-point interconnect.
- Grants go round-robin, one owner at a time. A master keeps ownership for as long as it holds CYC.
- The block sits between the master cores (BusCmd-driven bench masters) and the single slave.

Parameters:
- NM, 4, number of masters (1..8).
- AW, 3, address width.
- DW, 32, data width.
- WDOG_LIMIT, 16, cycles of unacknowledged STB before a bus-error termination (used only with the macro).

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- M_CYC_I  in  NM  per-master cycle request.
- M_STB_I  in  NM  per-master strobe.
- M_WE_I  in  NM  per-master write enable.
- M_ADR_I  in  NM*AW  flattened addresses; master k occupies bits [k*AW +: AW].
- M_DAT_I  in  NM*DW  flattened write data.
- M_ACK_O  out  NM  acknowledge, routed to the owner only.
- M_DAT_O  out  DW  read data, broadcast from S_DAT_I.
- GNT_O  out  NM  one-hot registered grant.
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave-side controls.
- S_ADR_O  out  AW  slave address.
- S_DAT_O  out  DW  slave write data.
- S_DAT_I  in  DW  slave read data.
- S_ACK_I  in  1  slave acknowledge.

Behaviour:
- Reset (RST_I=0 at an edge):
  - state=IDLE, GNT_O=0, priority pointer ptr=0, watchdog counter=0.
  - All M_ACK_O and S_CYC_O/S_STB_O/S_WE_O are 0. S_ADR_O and S_DAT_O are 0.
  - Reset mid-transfer drops the grant at that edge; the in-flight cycle is abandoned.
- States are IDLE and BUSY.
- Arbitration runs whenever state=IDLE, or state=BUSY and the owner's M_CYC_I=0:
  - Scan from ptr upward, modulo NM; the first master with M_CYC_I=1 wins.
  - The winner is loaded into GNT_O at the next edge and state becomes BUSY.
  - ptr is set to (winner+1) mod NM.
  - If there is no requester, go to IDLE with GNT_O=0.
  - Grant latency is one cycle from CYC to GNT_O. Handover to a new owner is one cycle; there is no dead cycle.
- While BUSY, the slave-side mux is combinational from the owner:
  - S_CYC_O = owner CYC, S_STB_O = owner STB.
  - S_WE_O, S_ADR_O and S_DAT_O come from the owner.
  - M_ACK_O[owner] = S_ACK_I; every other M_ACK_O bit is 0.
- The owner holding CYC with STB=0 keeps the bus (locked read-modify-write). Other requesters wait indefinitely.
- S_ACK_I while IDLE, or while the owner's STB=0, is ignored and not forwarded.
- Owner drops CYC in the same cycle as its ACK: that ACK is still forwarded, and re-arbitration occurs at the same edge.
- A newly asserted request from a non-owner never preempts the owner.
- NM=1: the grant is simply the registered M_CYC_I[0].
- Fairness: with all NM masters requesting continuously and each releasing after one transfer, grants rotate 0,1,...,NM-1,0.

Optional Feature:
- Macro WB_ARB_WDOG_EN.
- When defined:
  - Adds output M_ERR_O[NM].
  - The counter increments each cycle S_STB_O=1 and S_ACK_I=0, and clears on ACK or on a grant change.
  - On reaching WDOG_LIMIT, M_ERR_O[owner] pulses for one cycle and S_STB_O is forced to 0 that cycle. The counter clears; the owner keeps its grant until it drops CYC.
  - An ERR pulse and an ACK are never asserted in the same cycle; if the counter reaches the limit in the same cycle as ACK, ACK wins.
- When undefined: no M_ERR_O port, no counter, and a hung slave stalls the owner forever.

Decomposition:
- Package wb_arb_pkg:
  - state encoding (IDLE=0, BUSY=1)
  - clog2 function for ptr width
  - default AW/DW constants
- Sub-module wb_rr_pick: combinational round-robin priority encoder (req[NM], ptr -> one-hot winner, valid). This is the natural split.

Test Plan:
- Single master: m1 writes 0x0000_0005 to adr 3 → GNT_O=0010 one cycle after CYC; S_ADR_O=3, S_DAT_O=5; M_ACK_O=0010 on S_ACK_I; others 0.
- All four masters request at once, each doing one transfer then releasing → grant order 0,1,2,3,0; handover gap exactly one cycle.
- m2 holds CYC with STB low for 10 cycles while m0 requests → m0 ungranted until m2 drops CYC; next edge GNT_O=0001.
- Reset asserted during m3's read with STB high → next edge GNT_O=0, S_CYC_O=0, ptr=0; after release, simultaneous m1/m3 requests → m1 granted first.
- Stray S_ACK_I pulse while IDLE → no M_ACK_O bit set.
- With WB_ARB_WDOG_EN and a slave that never ACKs, WDOG_LIMIT=16 → M_ERR_O[owner] pulses on the 16th STB cycle, S_STB_O low that cycle.
